match_logger: RTL and testbench

- Downstream consumer of the string matcher's y_val output.
- Timestamps every match cycle during a session, counts matches, and buffers match timestamps in a small FIFO.
- Timestamps drain through a valid/ready interface to a host or debug port.
- Shares clk, reset and start with the matcher; its y_val input connects directly to the matcher's y_val.

---
 rtl/match_logger_pkg.sv | 22 ++
 rtl/match_logger_if.sv | 32 +++
 rtl/match_logger_fifo.sv | 87 ++++++++
 rtl/match_logger.sv | 124 ++++++++++++
 tb/tb_match_logger.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/match_logger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_logger_pkg
// Description : Shared types and default parameters for the match logger.
// Revision    : 1.0 - initial release
// ============================================================================
package match_logger_pkg;

  // Default configuration values.
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Session FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/match_logger_if.sv
`default_nettype none
// ============================================================================
// Module      : match_logger_if
// Description : Valid/ready timestamp stream from the logger to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_logger_if
  import match_logger_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) ();

  logic            ev_valid;
  logic            ev_ready;
  logic [TS_W-1:0] ev_ts;

  // Producer side (the logger).
  modport master (
    output ev_valid,
    output ev_ts,
    input  ev_ready
  );

  // Consumer side (host or debug port).
  modport slave (
    input  ev_valid,
    input  ev_ts,
    output ev_ready
  );

endinterface
`default_nettype wire

// File: rtl/match_logger_fifo.sv
`default_nettype none
// ============================================================================
// Module      : match_fifo
// Description : Synchronous FIFO with a registered head. The head register
//               keeps its last value once the FIFO empties.
// Revision    : 1.0 - initial release
// ============================================================================
module match_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (count_q == CW'(DEPTH));
  assign w_empty = (count_q == CW'(0));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop   = pop_i & ~w_empty;
  assign w_push  = push_i & (~w_full | w_pop);

  // Next pointer, occupancy and head values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);
    if (w_pop) begin
      if (count_q > CW'(1)) head_d = mem_q[rd_ptr_q + AW'(1)];
      else if (w_push)      head_d = din_i;
    end else if (w_push && w_empty) begin
      head_d = din_i;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are qualified by the occupancy counter.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = head_q;
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/match_logger.sv
`default_nettype none
// ============================================================================
// Module      : match_logger
// Description : Timestamps and counts matcher hits during a session and
//               streams the timestamps out through a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module match_logger
  import match_logger_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              y_val,
  match_logger_if.master    ev,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic              start_q;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              w_start_rise;
  logic [TS_W-1:0]   w_ts_cur;
  logic              w_match;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic              w_empty_after;
  logic [CW-1:0]     w_count;
  logic [TS_W-1:0]   w_head;

  assign w_start_rise = start & ~start_q;
  // The first cycle of a session is always timestamp zero.
  assign w_ts_cur     = w_start_rise ? '0 : ts_q;
  assign w_match      = start & y_val;
  assign w_pop        = ~w_empty & ev.ev_ready;
  assign w_push       = w_match & (~w_full | w_pop);
  assign w_drop       = w_match & w_full & ~w_pop;
  // Only consulted with start low, when nothing can be pushed.
  assign w_empty_after = w_empty | ((w_count == CW'(1)) & w_pop);

  match_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .din_i   (w_ts_cur),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Timestamp, match counter and sticky overflow next-state.
  always_comb begin
    ts_d  = ts_q;
    cnt_d = w_start_rise ? '0 : cnt_q;
    ovf_d = (w_start_rise ? 1'b0 : ovf_q) | w_drop;
    if (start) begin
      if (w_start_rise)  ts_d = TS_W'(1);
      else if (ts_q != '1) ts_d = ts_q + TS_W'(1);
    end
    if (w_match && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
  end

  // Session FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!start) state_d = w_empty_after ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (start)              state_d = RUN;
        else if (w_empty_after) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ts_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ev.ev_valid  = ~w_empty;
  assign ev.ev_ts     = w_head;
  assign match_count  = cnt_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_match_logger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_match_logger
// Description : Scoreboard bench for match_logger (default and narrow builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_logger;
  import match_logger_pkg::*;

  localparam int TS_W    = 16;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 4;
  localparam int S_TS_W  = 4;
  localparam int S_CNT_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic start, y_val;
  logic [CNT_W-1:0] match_count;
  logic overflow, busy;

  logic s_start, s_y;
  logic [S_CNT_W-1:0] s_count;
  logic s_ovf, s_busy;

  always #5 clk = ~clk;

  match_logger_if #(.TS_W(TS_W))   ev_if ();
  match_logger_if #(.TS_W(S_TS_W)) s_if ();

  match_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .y_val(y_val), .ev(ev_if),
    .match_count(match_count), .overflow(overflow), .busy(busy)
  );

  match_logger #(.TS_W(S_TS_W), .CNT_W(S_CNT_W), .DEPTH(DEPTH)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .y_val(s_y), .ev(s_if),
    .match_count(s_count), .overflow(s_ovf), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of the default-parameter DUT.
  logic [TS_W-1:0] sb [$];
  int              m_occ;
  logic [TS_W-1:0] m_ts;
  int              m_cnt;
  bit              m_ovf;
  bit              m_sq;
  state_t          m_state;
  logic [TS_W-1:0] m_last;

  task automatic model_reset();
    sb.delete();
    m_occ = 0; m_ts = '0; m_cnt = 0; m_ovf = 0; m_sq = 0;
    m_state = IDLE; m_last = '0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit st, input bit yv, input bit rdy);
    bit rise, pop, push, match, drop;
    logic [TS_W-1:0] cur_ts, exp_ts;
    @(negedge clk);
    chk("ev_valid", ev_if.ev_valid, (m_occ != 0));
    chk("match_count", match_count, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_state != IDLE));
    if (m_occ == 0) chk("ev_ts_hold", ev_if.ev_ts, m_last);
    start = st; y_val = yv; ev_if.ev_ready = rdy;
    #1;
    rise   = st & ~m_sq;
    cur_ts = rise ? '0 : m_ts;
    pop    = (m_occ != 0) && rdy;
    if (pop) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_ts = sb.pop_front();
        chk("ev_ts", ev_if.ev_ts, exp_ts);
        m_last = exp_ts;
      end
    end
    match = st & yv;
    push  = match && ((m_occ < DEPTH) || pop);
    drop  = match && !push;
    if (push) sb.push_back(cur_ts);
    m_occ = m_occ + int'(push) - int'(pop);
    if (rise) begin m_cnt = 0; m_ovf = 0; end
    if (match && m_cnt < (2**CNT_W - 1)) m_cnt++;
    if (drop) m_ovf = 1;
    if (st) m_ts = rise ? TS_W'(1) : ((m_ts == '1) ? m_ts : m_ts + TS_W'(1));
    case (m_state)
      IDLE:    if (st) m_state = RUN;
      RUN:     if (!st) m_state = (m_occ != 0) ? DRAIN : IDLE;
      DRAIN:   if (st) m_state = RUN; else if (m_occ == 0) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    m_sq = st;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 0; y_val = 0; ev_if.ev_ready = 0;
    s_start = 0; s_y = 0; s_if.ev_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", ev_if.ev_valid, 0);
    chk("rst_ts", ev_if.ev_ts, 0);
    chk("rst_count", match_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // Reset mid-run clears everything asynchronously.
    repeat (3) step(1, 1, 0);
    @(negedge clk);
    #2;
    reset = 1'b0; start = 0; y_val = 0; ev_if.ev_ready = 0;
    #1;
    chk("amid_valid", ev_if.ev_valid, 0);
    chk("amid_count", match_count, 0);
    chk("amid_ovf", overflow, 0);
    chk("amid_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Basic logging: matches at session cycles 2 and 5.
    for (int c = 0; c < 10; c++) begin
      step(1, (c == 2 || c == 5), 1);
      if (c == 3) begin
        chk("basic_v2", ev_if.ev_valid, 1);
        chk("basic_ts2", ev_if.ev_ts, 2);
      end
      if (c == 6) begin
        chk("basic_v5", ev_if.ev_valid, 1);
        chk("basic_ts5", ev_if.ev_ts, 5);
        chk("basic_cnt", match_count, 2);
      end
    end
    repeat (3) step(0, 0, 1);

    // Overflow: six matches into a four-entry FIFO with no reader.
    repeat (6) step(1, 1, 0);
    step(1, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", match_count, 6);
    chk("ovf_head", ev_if.ev_ts, 0);
    repeat (7) step(0, 0, 1);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    repeat (4) step(1, 1, 0);
    repeat (3) step(1, 1, 1);
    step(1, 0, 0);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_cnt", match_count, 7);
    repeat (7) step(0, 0, 1);

    // Drain, then restart while old entries are pending.
    repeat (2) step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("drain_busy", busy, 1);
    step(1, 0, 0);
    step(1, 1, 1);
    chk("restart_cnt", match_count, 0);
    chk("restart_head", ev_if.ev_ts, 0);
    repeat (3) step(1, 0, 1);
    repeat (4) step(0, 0, 1);
    chk("drain_idle", busy, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
    repeat (12) step(0, 0, 1);
    chk("sb_left", sb.size(), 0);

    // Saturation on the narrow build.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_start = 1; s_y = (c >= 10); s_if.ev_ready = 1;
    end
    @(negedge clk);
    s_start = 0; s_y = 0;
    chk("sat_ts", s_if.ev_ts, 15);
    chk("sat_cnt", s_count, 7);
    chk("sat_ovf", s_ovf, 0);
    repeat (3) @(negedge clk);
    chk("sat_valid", s_if.ev_valid, 0);
    chk("sat_busy", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
